// File: rtl/radar_statistics_avg_if.sv
// Radar pulse inputs and timing measurement outputs.
// Carries one radar_statistics_avg instance.
interface radar_statistics_avg_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  USEC_PE;
  logic                  RADAR_ARP_PE;
  logic                  RADAR_ACP_PE;
  logic                  RADAR_TRIG_PE;
  logic [DATA_WIDTH-1:0] RADAR_ARP_US;
  logic [DATA_WIDTH-1:0] RADAR_ARP_US_AVG;
  logic [DATA_WIDTH-1:0] RADAR_ACP_CNT;
  logic [DATA_WIDTH-1:0] RADAR_TRIG_US;
  logic [DATA_WIDTH-1:0] RADAR_TRIG_US_AVG;
  logic                  UPDATE;
  logic                  CALIBRATED;
  logic                  ARP_LOST;

  modport master (
    output USEC_PE, RADAR_ARP_PE,
    output RADAR_ACP_PE, RADAR_TRIG_PE,
    input  RADAR_ARP_US, RADAR_ARP_US_AVG,
    input  RADAR_ACP_CNT, RADAR_TRIG_US,
    input  RADAR_TRIG_US_AVG, UPDATE,
    input  CALIBRATED, ARP_LOST
  );

  modport slave (
    input  USEC_PE, RADAR_ARP_PE,
    input  RADAR_ACP_PE, RADAR_TRIG_PE,
    output RADAR_ARP_US, RADAR_ARP_US_AVG,
    output RADAR_ACP_CNT, RADAR_TRIG_US,
    output RADAR_TRIG_US_AVG, UPDATE,
    output CALIBRATED, ARP_LOST
  );
endinterface

// File: rtl/radar_statistics_avg.sv
// Radar ARP/ACP/TRIG timing monitor with averaging, lock and loss.
// RADAR_STATS_TRIG_AVG_EN builds a sliding-mean window for TRIG.
module radar_statistics_avg #(
  parameter int DATA_WIDTH = 32,
  parameter int AVG_LOG2   = 2,
  parameter int STABLE_CNT = 4,
  parameter int TOL_US     = 8,
  parameter int TIMEOUT_US = 1000
) (
  input  logic S_AXIS_ACLK,
  input  logic S_AXIS_ARESETN,
  radar_statistics_avg_if.slave bus
);
  localparam int DW  = DATA_WIDTH;
  localparam int N   = 1 << AVG_LOG2;
  localparam int SW  = DW + AVG_LOG2;
  localparam int FW  = $clog2(N + 1);
  localparam int STW = $clog2(STABLE_CNT + 1);

  localparam logic [DW-1:0]  MAXV = '1;
  localparam logic [DW-1:0]  TOL  = DW'(TOL_US);
  localparam logic [DW-1:0]  TLST = DW'(TIMEOUT_US - 1);
  localparam logic [FW-1:0]  FULL = FW'(N);
  localparam logic [STW-1:0] SMAX = STW'(STABLE_CNT);

  typedef enum logic [1:0] {
    IDLE, ARMED, MEASURE, LOCKED
  } state_t;

  function automatic logic [DW-1:0] sat_inc(
    input logic [DW-1:0] x,
    input logic          en
  );
    return (en && x != MAXV) ? x + 1'b1 : x;
  endfunction

  state_t              state;
  logic [DW-1:0]       arp_cnt, acp_cnt, trig_cnt;
  logic                trig_armed;
  logic [DW-1:0]       arp_us_q, acp_q, arp_avg_q;
  logic [DW-1:0]       trig_us_q;
  logic [N-1:0][DW-1:0] arp_win;
  logic [SW-1:0]       arp_sum;
  logic [FW-1:0]       arp_fill;
  logic [STW-1:0]      stable;
  logic                update_q, cal_q, lost_q;

  logic          usec, arp_pe, acp_pe, trig_pe;
  logic [DW-1:0] arp_cap, acp_cap, trig_cap, dev;
  logic          timeout, in_tol, arp_full_nx;
  logic [SW-1:0] arp_sum_nx;
  logic [FW-1:0] arp_fill_nx;
  logic [STW-1:0] stable_inc;

  assign usec    = bus.USEC_PE;
  assign arp_pe  = bus.RADAR_ARP_PE;
  assign acp_pe  = bus.RADAR_ACP_PE;
  assign trig_pe = bus.RADAR_TRIG_PE;

  // a tick or pulse coincident with the closing edge belongs to the old period
  assign arp_cap  = sat_inc(arp_cnt, usec);
  assign acp_cap  = sat_inc(acp_cnt, acp_pe);
  assign trig_cap = sat_inc(trig_cnt, usec);

  assign timeout = (state != IDLE) && !arp_pe
                && usec && (arp_cnt == TLST);

  assign dev = (arp_cap >= arp_us_q) ? arp_cap - arp_us_q
                                     : arp_us_q - arp_cap;
  assign in_tol = (dev <= TOL);

  assign arp_sum_nx  = arp_sum + SW'(arp_cap)
                     - SW'(arp_win[N-1]);
  assign arp_fill_nx = (arp_fill == FULL) ? arp_fill
                                          : arp_fill + 1'b1;
  assign arp_full_nx = (arp_fill_nx == FULL);
  assign stable_inc  = (stable == SMAX) ? stable
                                        : stable + 1'b1;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state      <= IDLE;
      arp_cnt    <= '0;
      acp_cnt    <= '0;
      trig_cnt   <= '0;
      trig_armed <= 1'b0;
      arp_us_q   <= '0;
      acp_q      <= '0;
      arp_avg_q  <= '0;
      trig_us_q  <= '0;
      arp_win    <= '0;
      arp_sum    <= '0;
      arp_fill   <= '0;
      stable     <= '0;
      update_q   <= 1'b0;
      cal_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      update_q <= 1'b0;
      arp_cnt  <= sat_inc(arp_cnt, usec);
      acp_cnt  <= sat_inc(acp_cnt, acp_pe);
      trig_cnt <= sat_inc(trig_cnt, usec);
      if (timeout) begin
        state      <= IDLE;
        lost_q     <= 1'b1;
        cal_q      <= 1'b0;
        stable     <= '0;
        arp_cnt    <= '0;
        acp_cnt    <= '0;
        trig_cnt   <= '0;
        trig_armed <= 1'b0;
        arp_us_q   <= '0;
        acp_q      <= '0;
        arp_avg_q  <= '0;
        trig_us_q  <= '0;
        arp_win    <= '0;
        arp_sum    <= '0;
        arp_fill   <= '0;
      end else begin
        if (arp_pe) begin
          arp_cnt <= '0;
          acp_cnt <= '0;
          if (state == IDLE) begin
            state  <= ARMED;
            lost_q <= 1'b0;
          end else begin
            arp_us_q  <= arp_cap;
            acp_q     <= acp_cap;
            update_q  <= 1'b1;
            arp_win   <= {arp_win[N-2:0], arp_cap};
            arp_sum   <= arp_sum_nx;
            arp_fill  <= arp_fill_nx;
            arp_avg_q <= arp_full_nx
                       ? arp_sum_nx[SW-1:AVG_LOG2] : '0;
            unique case (state)
              ARMED: begin
                state  <= MEASURE;
                stable <= '0;
              end
              MEASURE: begin
                if (in_tol) begin
                  stable <= stable_inc;
                  if (stable_inc == SMAX && arp_full_nx) begin
                    state <= LOCKED;
                    cal_q <= 1'b1;
                  end
                end else begin
                  stable <= '0;
                end
              end
              LOCKED: begin
                if (!in_tol) begin
                  state  <= MEASURE;
                  stable <= '0;
                  cal_q  <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        if (trig_pe) begin
          trig_cnt   <= '0;
          trig_armed <= 1'b1;
          if (trig_armed) trig_us_q <= trig_cap;
        end
      end
    end
  end

  assign bus.RADAR_ARP_US     = arp_us_q;
  assign bus.RADAR_ARP_US_AVG = arp_avg_q;
  assign bus.RADAR_ACP_CNT    = acp_q;
  assign bus.RADAR_TRIG_US    = trig_us_q;
  assign bus.UPDATE           = update_q;
  assign bus.CALIBRATED       = cal_q;
  assign bus.ARP_LOST         = lost_q;

`ifdef RADAR_STATS_TRIG_AVG_EN
  logic [N-1:0][DW-1:0] trig_win;
  logic [SW-1:0]        trig_sum, trig_sum_nx;
  logic [FW-1:0]        trig_fill, trig_fill_nx;
  logic [DW-1:0]        trig_avg_q;
  logic                 trig_cap_en;

  assign trig_cap_en  = trig_pe && trig_armed && !timeout;
  assign trig_sum_nx  = trig_sum + SW'(trig_cap)
                      - SW'(trig_win[N-1]);
  assign trig_fill_nx = (trig_fill == FULL) ? trig_fill
                                            : trig_fill + 1'b1;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      trig_win   <= '0;
      trig_sum   <= '0;
      trig_fill  <= '0;
      trig_avg_q <= '0;
    end else if (timeout) begin
      trig_win   <= '0;
      trig_sum   <= '0;
      trig_fill  <= '0;
      trig_avg_q <= '0;
    end else if (trig_cap_en) begin
      trig_win   <= {trig_win[N-2:0], trig_cap};
      trig_sum   <= trig_sum_nx;
      trig_fill  <= trig_fill_nx;
      trig_avg_q <= (trig_fill_nx == FULL)
                  ? trig_sum_nx[SW-1:AVG_LOG2] : '0;
    end
  end

  assign bus.RADAR_TRIG_US_AVG = trig_avg_q;
`else
  assign bus.RADAR_TRIG_US_AVG = trig_us_q;
`endif
endmodule

// File: tb/tb_radar_statistics_avg.sv
// Scoreboard bench for radar_statistics_avg (default and 8-bit builds).
// One microsecond is two clocks; ARP periods are given in microseconds.
module tb_radar_statistics_avg;
  logic clk;
  logic rst_n;

  radar_statistics_avg_if #(.DATA_WIDTH(32)) bus ();
  radar_statistics_avg_if #(.DATA_WIDTH(8))  bus_s ();

  radar_statistics_avg u_dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .bus            (bus.slave)
  );

  radar_statistics_avg #(
    .DATA_WIDTH (8),
    .TIMEOUT_US (200)
  ) u_sat (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .bus            (bus_s.slave)
  );

  typedef struct {
    logic [31:0] arp;
    logic [31:0] acp;
    logic [31:0] avg;
    logic        cal;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(
    input int arp, input int acp,
    input int avg, input bit cal
  );
    exp_t e;
    e.arp = 32'(arp);
    e.acp = 32'(acp);
    e.avg = 32'(avg);
    e.cal = cal;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (bus.UPDATE === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL upd_unexpected observed=1 expected=0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("arp_us",  bus.RADAR_ARP_US,     e.arp);
        chk("acp_cnt", bus.RADAR_ACP_CNT,    e.acp);
        chk("arp_avg", bus.RADAR_ARP_US_AVG, e.avg);
        chk("calib",   32'(bus.CALIBRATED),  32'(e.cal));
      end
    end
  end

  task automatic drive(
    input bit u, input bit a, input bit c,
    input bit t, input bit su, input bit st
  );
    bus.USEC_PE         = u;
    bus.RADAR_ARP_PE    = a;
    bus.RADAR_ACP_PE    = c;
    bus.RADAR_TRIG_PE   = t;
    bus_s.USEC_PE       = su;
    bus_s.RADAR_TRIG_PE = st;
    @(posedge clk);
    #1;
  endtask

  // ARP closes the period in its last cycle, with no coincident tick,
  // unless coinc adds one extra cycle carrying ARP+ACP+USEC together.
  task automatic period(
    input int p, input bit coinc,
    input bit push, input exp_t e
  );
    int n;
    n = 2 * p;
    for (int j = 0; j < n; j++) begin
      bit a;
      a = (j == n - 1) && !coinc;
      if (a && push) q.push_back(e);
      drive(j % 2 == 0, a, j % 50 == 0, j % 10 == 0, 0, 0);
    end
    if (coinc) begin
      if (push) q.push_back(e);
      drive(1, 1, 1, 0, 0, 0);
    end
  endtask

  task automatic gap_s(input int us);
    for (int j = 0; j < 2 * us; j++)
      drive(0, 0, 0, 0, j % 2 == 0, j == 2 * us - 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_arp"},  bus.RADAR_ARP_US,      0);
    chk({tag, "_avg"},  bus.RADAR_ARP_US_AVG,  0);
    chk({tag, "_acp"},  bus.RADAR_ACP_CNT,     0);
    chk({tag, "_trig"}, bus.RADAR_TRIG_US,     0);
    chk({tag, "_tavg"}, bus.RADAR_TRIG_US_AVG, 0);
    chk({tag, "_cal"},  32'(bus.CALIBRATED),   0);
  endtask

  exp_t nx;
  int   ticks;

  initial begin
    nx = mk(0, 0, 0, 0);
    rst_n = 1'b0;
    bus.USEC_PE = 0;
    bus.RADAR_ARP_PE = 0;
    bus.RADAR_ACP_PE = 0;
    bus.RADAR_TRIG_PE = 0;
    bus_s.USEC_PE = 0;
    bus_s.RADAR_ARP_PE = 0;
    bus_s.RADAR_ACP_PE = 0;
    bus_s.RADAR_TRIG_PE = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    chk("rst_lost", 32'(bus.ARP_LOST), 0);
    rst_n = 1'b1;

    // arm, then reach lock on the 6th ARP
    period(125, 0, 0, nx);
    period(125, 0, 1, mk(125, 5, 0, 0));
    chk("trig_us",  bus.RADAR_TRIG_US,     5);
    chk("trig_avg", bus.RADAR_TRIG_US_AVG, 5);
    period(125, 0, 1, mk(125, 5, 0, 0));
    period(125, 0, 1, mk(125, 5, 0, 0));
    period(125, 0, 1, mk(125, 5, 125, 0));
    period(125, 0, 1, mk(125, 5, 125, 1));

    // step out of tolerance and relock
    period(135, 0, 1, mk(135, 6, 127, 0));
    period(125, 0, 1, mk(125, 5, 127, 0));
    period(125, 0, 1, mk(125, 5, 127, 0));
    period(125, 0, 1, mk(125, 5, 127, 0));
    period(125, 0, 1, mk(125, 5, 125, 0));
    period(125, 0, 1, mk(125, 5, 125, 1));

    // coincident closing edge, then a clean period
    period(125, 1, 1, mk(126, 6, 125, 1));
    period(125, 0, 1, mk(125, 5, 125, 1));

    // ARP loss after 1000 ticks
    ticks = 0;
    for (int k = 0; k < 2400; k++) begin
      bit u;
      u = (k % 2 == 0);
      drive(u, 0, 0, 0, 0, 0);
      if (u) ticks++;
      if (u && ticks == 999)
        chk("lost_early", 32'(bus.ARP_LOST), 0);
      if (ticks == 1000) break;
    end
    chk("loss_ticks", 32'(ticks), 1000);
    chk("lost_set", 32'(bus.ARP_LOST), 1);
    chk_zero("lost");

    // resume: arming edge clears the flag, second edge captures
    period(125, 0, 0, nx);
    chk("lost_clr", 32'(bus.ARP_LOST), 0);
    period(125, 0, 1, mk(125, 5, 0, 0));

    // asynchronous reset mid-period
    repeat (30) drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    chk("arst_upd", 32'(bus.UPDATE), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    period(125, 0, 0, nx);
    period(125, 0, 1, mk(125, 5, 0, 0));
    repeat (5) drive(0, 0, 0, 0, 0, 0);
    chk("sb_empty", 32'(q.size()), 0);

    // 8-bit build: TRIG saturation and TRIG averaging
    gap_s(5);
    gap_s(300);
    chk("sat_trig", 32'(bus_s.RADAR_TRIG_US), 255);
`ifdef RADAR_STATS_TRIG_AVG_EN
    chk("sat_tavg0", 32'(bus_s.RADAR_TRIG_US_AVG), 0);
    gap_s(10);
    chk("sat_tavg1", 32'(bus_s.RADAR_TRIG_US_AVG), 0);
    gap_s(10);
    chk("sat_tavg2", 32'(bus_s.RADAR_TRIG_US_AVG), 0);
    gap_s(10);
    chk("sat_trig4", 32'(bus_s.RADAR_TRIG_US), 10);
    chk("sat_tavg3", 32'(bus_s.RADAR_TRIG_US_AVG), 71);
`else
    chk("sat_tavg0", 32'(bus_s.RADAR_TRIG_US_AVG), 255);
    gap_s(10);
    chk("sat_trig2", 32'(bus_s.RADAR_TRIG_US), 10);
    chk("sat_tavg1", 32'(bus_s.RADAR_TRIG_US_AVG), 10);
`endif
    chk("sat_lost", 32'(bus_s.ARP_LOST), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
